// File: rtl/slc3_mult_pkg.sv
// ============================================================================
// Module   : slc3_mult_pkg
// Purpose  : Shared types, constants and helpers for the SLC3 sequential
//            multiplier (seq_mult16) and its carry-lookahead adder.
// Contents : mult_state_t  - multiplier control states
//            MULT_WIDTH    - operand width
//            MULT_CNT_W    - iteration counter width
//            ext_operand() - sign/zero extension of an operand by one bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slc3_mult_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int MULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Extends an operand by one bit: the sign bit when sgn is set,
    // otherwise a zero.
    function automatic logic [MULT_WIDTH:0] ext_operand(
        input logic [MULT_WIDTH-1:0] op,
        input logic                  sgn
    );
        return {sgn & op[MULT_WIDTH-1], op};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult16_cla_add17.sv
// ============================================================================
// Module   : cla_add17
// Purpose  : (WIDTH+1)-bit hierarchical carry-lookahead adder. The low WIDTH
//            bits are built from WIDTH/4 4-bit CLA slices; a second-level
//            lookahead unit produces every slice carry-in directly from the
//            slice group propagate/generate terms. The top (extension) bit is
//            a single full-adder whose carry-in comes from the group
//            lookahead. Purely combinational.
// Ports    : a, b  [WIDTH:0] in   addends
//            cin         in   carry-in
//            s     [WIDTH:0] out  sum
//            cout        out  carry-out of the extension bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_add17
    import slc3_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           cin,
    output logic [WIDTH:0] s,
    output logic           cout
);

    localparam int NSLICE = WIDTH / 4;

    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  g;
    logic [NSLICE-1:0] grp_p;
    logic [NSLICE-1:0] grp_g;
    // grp_c[k] is the carry into slice k; grp_c[NSLICE] feeds the extension bit.
    logic [NSLICE:0]   grp_c;
    logic              ext_p;

    assign p = a[WIDTH-1:0] ^ b[WIDTH-1:0];
    assign g = a[WIDTH-1:0] & b[WIDTH-1:0];

    generate
        for (genvar k = 0; k < NSLICE; k++) begin : g_slice
            logic [3:0] sp;
            logic [3:0] sg;
            logic [3:0] c;

            assign sp = p[4*k +: 4];
            assign sg = g[4*k +: 4];

            // Fully expanded in-slice carries: no ripple inside the slice.
            assign c[0] = grp_c[k];
            assign c[1] = sg[0] | (sp[0] & c[0]);
            assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
            assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                        | (sp[2] & sp[1] & sp[0] & c[0]);

            assign s[4*k +: 4] = sp ^ c;

            assign grp_p[k] = &sp;
            assign grp_g[k] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                            | (sp[3] & sp[2] & sp[1] & sg[0]);
        end
    endgenerate

    // Second-level lookahead: each group carry is the OR of every lower group
    // generate gated by the propagates above it, plus cin gated by all
    // propagates below. The loop only enumerates those product terms.
    always_comb begin
        logic ck;
        logic prop;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int k = 1; k <= NSLICE; k++) begin
            ck   = 1'b0;
            prop = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                ck   = ck | (grp_g[j] & prop);
                prop = prop & grp_p[j];
            end
            grp_c[k] = ck | (prop & cin);
        end
    end

    assign ext_p    = a[WIDTH] ^ b[WIDTH];
    assign s[WIDTH] = ext_p ^ grp_c[NSLICE];
    assign cout     = (a[WIDTH] & b[WIDTH]) | (ext_p & grp_c[NSLICE]);

endmodule

`default_nettype wire

// File: rtl/seq_mult16.sv
// ============================================================================
// Module   : seq_mult16
// Purpose  : WIDTH x WIDTH sequential shift-add multiplier for the SLC3
//            datapath. One accumulate plus right shift per cycle through a
//            hierarchical CLA; WIDTH cycles from acceptance to product.
//            One operation in flight, valid/ready on both sides.
// Config   : MULT_SIGNED_EN - when defined, operands are two's complement
//            (sign-extended multiplicand, subtract on the last iteration,
//            arithmetic shift). Undefined: unsigned operation.
// Ports    : Clk                   in   clock, rising edge
//            Reset_n               in   asynchronous active-low reset
//            in_valid / in_ready   in/out operand handshake
//            mcand, mplier [W]     in   multiplicand / multiplier
//            out_valid / out_ready out/in product handshake
//            product [2W]          out  registered A*B, held in DONE
//            busy                  out  high in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult16
    import slc3_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    mult_state_t      state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m;
    logic [CNT_W-1:0] cnt;

    logic             last_iter;
    logic             do_sub;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             sum_cout;
    logic             shift_in;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    // The MSB of a two's complement multiplier carries negative weight, so
    // its partial product is subtracted.
    assign do_sub    = SIGNED_MODE && last_iter;

    // With Q[0]=0 the adder sees ACC + 0 + 0, so S = ACC and carry-out = 0.
    assign add_b   = q[0] ? (do_sub ? ~m : m) : '0;
    assign add_cin = q[0] & do_sub;

    cla_add17 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc),
        .b    (add_b),
        .cin  (add_cin),
        .s    (sum),
        .cout (sum_cout)
    );

    // Signed: replicate the sum's sign. Unsigned: keep the adder carry.
    assign shift_in = SIGNED_MODE ? sum[WIDTH] : sum_cout;
    assign acc_nxt  = {shift_in, sum[WIDTH:1]};
    assign q_nxt    = {sum[0], q[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m        <= ext_operand(mcand, SIGNED_MODE);
                        q        <= mplier;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        // Capture from the shifted values so product is valid
                        // in the same cycle out_valid rises.
                        product   <= {acc_nxt[WIDTH-1:0], q_nxt};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
